// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : pc_sequencer
// Description: Next-PC controller for a pipelined MIPS fetch stage. Handles
//              boot, sequential fetch, redirects, stalls, imem wait and halt.
// Revision   : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
    parameter int               CNT_WIDTH    = 16
) (
    input  logic                 PCS_CLK,
    input  logic                 PCS_RST,
    input  logic [WIDTH-1:0]     PCS_PC_CUR,
    input  logic                 PCS_IMEM_READY,
    input  logic                 PCS_LOAD_USE,
    input  logic                 PCS_BRANCH_TAKEN,
    input  logic [WIDTH-1:0]     PCS_BRANCH_TGT,
    input  logic                 PCS_JUMP,
    input  logic [WIDTH-1:0]     PCS_JUMP_TGT,
    input  logic                 PCS_EXC,
    input  logic                 PCS_HALT,
    input  logic                 PCS_RESUME,
    output logic [WIDTH-1:0]     PCS_NEXT_PC,
    output logic                 PCS_PC_EN,
    output logic                 PCS_IMEM_REQ,
    output logic                 PCS_IFID_EN,
    output logic                 PCS_IFID_FLUSH,
    output logic [CNT_WIDTH-1:0] PCS_STALL_CNT
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    state_t                state, state_nx;
    logic                  pend_vld, pend_vld_nx;
    logic [WIDTH-1:0]      pend_addr, pend_addr_nx;
    logic [CNT_WIDTH-1:0]  stall_cnt;

    logic [WIDTH-1:0] exc_aligned;
    logic [WIDTH-1:0] br_aligned;
    logic [WIDTH-1:0] jmp_aligned;
    logic [WIDTH-1:0] seq_pc;

    assign exc_aligned = EXC_VECTOR & ALIGN_MASK;
    assign br_aligned  = PCS_BRANCH_TGT & ALIGN_MASK;
    assign jmp_aligned = PCS_JUMP_TGT & ALIGN_MASK;
    assign seq_pc      = PCS_PC_CUR + WIDTH'(4);

    always_comb begin
        PCS_NEXT_PC    = PCS_PC_CUR;
        PCS_PC_EN      = 1'b0;
        PCS_IMEM_REQ   = 1'b0;
        PCS_IFID_EN    = 1'b0;
        PCS_IFID_FLUSH = 1'b0;
        state_nx       = state;
        pend_vld_nx    = pend_vld;
        pend_addr_nx   = pend_addr;

        case (state)
            ST_BOOT: begin
                PCS_NEXT_PC    = RESET_VECTOR & ALIGN_MASK;
                PCS_PC_EN      = 1'b1;
                PCS_IFID_FLUSH = 1'b1;
                state_nx       = ST_RUN;
            end

            ST_RUN: begin
                PCS_IMEM_REQ = 1'b1;
                if (PCS_HALT) begin
                    // Freeze fetch; any pending redirect survives the halt.
                    state_nx = ST_HALT;
                end else if (!PCS_IMEM_READY) begin
                    if (PCS_EXC) begin
                        pend_vld_nx  = 1'b1;
                        pend_addr_nx = exc_aligned;
                    end else if (!pend_vld && PCS_BRANCH_TAKEN) begin
                        pend_vld_nx  = 1'b1;
                        pend_addr_nx = br_aligned;
                    end else if (!pend_vld && PCS_JUMP) begin
                        pend_vld_nx  = 1'b1;
                        pend_addr_nx = jmp_aligned;
                    end
                end else if (PCS_EXC) begin
                    PCS_NEXT_PC    = exc_aligned;
                    PCS_PC_EN      = 1'b1;
                    PCS_IFID_FLUSH = 1'b1;
                    pend_vld_nx    = 1'b0;
                end else if (pend_vld) begin
                    PCS_NEXT_PC    = pend_addr;
                    PCS_PC_EN      = 1'b1;
                    PCS_IFID_FLUSH = 1'b1;
                    pend_vld_nx    = 1'b0;
                end else if (PCS_BRANCH_TAKEN) begin
                    PCS_NEXT_PC    = br_aligned;
                    PCS_PC_EN      = 1'b1;
                    PCS_IFID_FLUSH = 1'b1;
                end else if (PCS_JUMP) begin
                    PCS_NEXT_PC    = jmp_aligned;
                    PCS_PC_EN      = 1'b1;
                    PCS_IFID_FLUSH = 1'b1;
                end else if (!PCS_LOAD_USE) begin
                    PCS_NEXT_PC    = seq_pc;
                    PCS_PC_EN      = 1'b1;
                    PCS_IFID_EN    = 1'b1;
                end
                // A flush loads a bubble, so the IF/ID register must be enabled.
                if (PCS_IFID_FLUSH) begin
                    PCS_IFID_EN = 1'b1;
                end
            end

            ST_HALT: begin
                PCS_IFID_FLUSH = 1'b1;
                if (PCS_RESUME) begin
                    state_nx = ST_RUN;
                end
            end

            default: begin
                state_nx = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge PCS_CLK) begin
        if (PCS_RST) begin
            state     <= ST_BOOT;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nx;
            pend_vld  <= pend_vld_nx;
            pend_addr <= pend_addr_nx;
            if ((state == ST_RUN) && !PCS_PC_EN && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign PCS_STALL_CNT = stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : tb_pc_sequencer
// Description: Vector-table bench with scoreboard queue for pc_sequencer.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [5:0] LU = 6'b100000;
    localparam logic [5:0] BR = 6'b010000;
    localparam logic [5:0] JP = 6'b001000;
    localparam logic [5:0] EX = 6'b000100;
    localparam logic [5:0] HT = 6'b000010;
    localparam logic [5:0] RS = 6'b000001;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [5:0]  fl;
        logic [31:0] pc;
        logic [31:0] bt;
        logic [31:0] jt;
        logic [31:0] e_next;
        logic        e_en;
        logic        e_req;
        logic        e_ifid;
        logic        e_flush;
        logic [15:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic        imem_ready, load_use, branch_taken, jump, exc, halt, resume;
    logic [31:0] branch_tgt, jump_tgt;
    logic [31:0] next_pc;
    logic        pc_en, imem_req, ifid_en, ifid_flush;
    logic [15:0] stall_cnt;

    int   n_vec  = 0;
    int   n_fail = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .PCS_CLK          (clk),
        .PCS_RST          (rst),
        .PCS_PC_CUR       (pc_cur),
        .PCS_IMEM_READY   (imem_ready),
        .PCS_LOAD_USE     (load_use),
        .PCS_BRANCH_TAKEN (branch_taken),
        .PCS_BRANCH_TGT   (branch_tgt),
        .PCS_JUMP         (jump),
        .PCS_JUMP_TGT     (jump_tgt),
        .PCS_EXC          (exc),
        .PCS_HALT         (halt),
        .PCS_RESUME       (resume),
        .PCS_NEXT_PC      (next_pc),
        .PCS_PC_EN        (pc_en),
        .PCS_IMEM_REQ     (imem_req),
        .PCS_IFID_EN      (ifid_en),
        .PCS_IFID_FLUSH   (ifid_flush),
        .PCS_STALL_CNT    (stall_cnt)
    );

    function automatic vec_t mk(input logic r, input logic rd, input logic [5:0] f,
                                input logic [31:0] p, input logic [31:0] b, input logic [31:0] j,
                                input logic [31:0] en_pc, input logic en, input logic rq,
                                input logic ie, input logic fx, input logic [15:0] c);
        vec_t v;
        v.rst = r; v.rdy = rd; v.fl = f; v.pc = p; v.bt = b; v.jt = j;
        v.e_next = en_pc; v.e_en = en; v.e_req = rq; v.e_ifid = ie; v.e_flush = fx; v.e_cnt = c;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst          = v.rst;
        imem_ready   = v.rdy;
        load_use     = v.fl[5];
        branch_taken = v.fl[4];
        jump         = v.fl[3];
        exc          = v.fl[2];
        halt         = v.fl[1];
        resume       = v.fl[0];
        pc_cur       = v.pc;
        branch_tgt   = v.bt;
        jump_tgt     = v.jt;
    endtask

    // Drive, record expectation, compare mid-cycle, then advance one clock.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        drive(v);
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (next_pc !== e.e_next || pc_en !== e.e_en || imem_req !== e.e_req ||
            ifid_en !== e.e_ifid || ifid_flush !== e.e_flush || stall_cnt !== e.e_cnt) begin
            n_fail++;
            $display("FAIL vec%0d: got next=%h en=%b req=%b ifid=%b flush=%b cnt=%0d; want next=%h en=%b req=%b ifid=%b flush=%b cnt=%0d",
                     idx, next_pc, pc_en, imem_req, ifid_en, ifid_flush, stall_cnt,
                     e.e_next, e.e_en, e.e_req, e.e_ifid, e.e_flush, e.e_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        //                r  rdy flags    pc            btgt     jtgt     next          en req ie fl cnt
        tbl.push_back(mk(1, 1, 6'b0,     32'h0,        32'h0,   32'h0,   32'h0,        1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, JP,       32'h0,        32'h0,   32'h500, 32'h0,        1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 6'b0,     32'h0,        32'h0,   32'h0,   32'h4,        1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, BR|JP,    32'h40,       32'h103, 32'h200, 32'h100,      1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'b0,     32'h100,      32'h0,   32'h0,   32'h104,      1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, JP,       32'h104,      32'h0,   32'h200, 32'h104,      0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 6'b0,     32'h104,      32'h0,   32'h0,   32'h104,      0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 6'b0,     32'h104,      32'h0,   32'h0,   32'h104,      0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 1, 6'b0,     32'h104,      32'h0,   32'h0,   32'h200,      1, 1, 1, 1, 3));
        tbl.push_back(mk(0, 1, 6'b0,     32'h200,      32'h0,   32'h0,   32'h204,      1, 1, 1, 0, 3));
        tbl.push_back(mk(0, 0, BR,       32'h204,      32'h80,  32'h0,   32'h204,      0, 1, 0, 0, 3));
        tbl.push_back(mk(0, 0, EX,       32'h204,      32'h0,   32'h0,   32'h204,      0, 1, 0, 0, 4));
        tbl.push_back(mk(0, 1, 6'b0,     32'h204,      32'h0,   32'h0,   32'h180,      1, 1, 1, 1, 5));
        tbl.push_back(mk(0, 0, JP,       32'h180,      32'h0,   32'h302, 32'h180,      0, 1, 0, 0, 5));
        tbl.push_back(mk(0, 0, BR,       32'h180,      32'h400, 32'h0,   32'h180,      0, 1, 0, 0, 6));
        tbl.push_back(mk(0, 1, BR,       32'h180,      32'h500, 32'h0,   32'h300,      1, 1, 1, 1, 7));
        tbl.push_back(mk(0, 1, 6'b0,     32'hFFFF_FFFC, 32'h0,  32'h0,   32'h0,        1, 1, 1, 0, 7));
        tbl.push_back(mk(0, 1, LU,       32'h0,        32'h0,   32'h0,   32'h0,        0, 1, 0, 0, 7));
        tbl.push_back(mk(0, 1, LU,       32'h0,        32'h0,   32'h0,   32'h0,        0, 1, 0, 0, 8));
        tbl.push_back(mk(0, 1, 6'b0,     32'h0,        32'h0,   32'h0,   32'h4,        1, 1, 1, 0, 9));
        tbl.push_back(mk(0, 1, EX|BR,    32'h10,       32'h80,  32'h0,   32'h180,      1, 1, 1, 1, 9));
        tbl.push_back(mk(0, 0, JP,       32'h180,      32'h0,   32'h600, 32'h180,      0, 1, 0, 0, 9));
        tbl.push_back(mk(0, 0, HT|RS,    32'h180,      32'h0,   32'h0,   32'h180,      0, 1, 0, 0, 10));
        tbl.push_back(mk(0, 1, BR|EX|LU, 32'h180,      32'h80,  32'h0,   32'h180,      0, 0, 0, 1, 11));
        tbl.push_back(mk(0, 1, 6'b0,     32'h180,      32'h0,   32'h0,   32'h180,      0, 0, 0, 1, 11));
        tbl.push_back(mk(0, 1, RS,       32'h180,      32'h0,   32'h0,   32'h180,      0, 0, 0, 1, 11));
        tbl.push_back(mk(0, 1, 6'b0,     32'h180,      32'h0,   32'h0,   32'h600,      1, 1, 1, 1, 11));
        tbl.push_back(mk(0, 0, JP,       32'h600,      32'h0,   32'h700, 32'h600,      0, 1, 0, 0, 11));
        tbl.push_back(mk(0, 0, HT,       32'h600,      32'h0,   32'h0,   32'h600,      0, 1, 0, 0, 12));
        tbl.push_back(mk(1, 1, 6'b0,     32'h600,      32'h0,   32'h0,   32'h600,      0, 0, 0, 1, 13));
        tbl.push_back(mk(0, 1, 6'b0,     32'h600,      32'h0,   32'h0,   32'h0,        1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 6'b0,     32'h0,        32'h0,   32'h0,   32'h4,        1, 1, 1, 0, 0));

        idle = mk(1, 0, 6'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        drive(idle);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Counter saturation: long imem wait from a clean RUN state.
        idle = mk(0, 0, 6'b0, 32'h40, 32'h0, 32'h0, 32'h40, 0, 1, 0, 0, 0);
        drive(idle);
        repeat (65534) @(posedge clk);
        #1;
        apply(mk(0, 0, 6'b0, 32'h40, 32'h0, 32'h0, 32'h40, 0, 1, 0, 0, 16'hFFFE), 100);
        apply(mk(0, 0, 6'b0, 32'h40, 32'h0, 32'h0, 32'h40, 0, 1, 0, 0, 16'hFFFF), 101);
        apply(mk(0, 0, 6'b0, 32'h40, 32'h0, 32'h0, 32'h40, 0, 1, 0, 0, 16'hFFFF), 102);
        apply(mk(0, 1, 6'b0, 32'h40, 32'h0, 32'h0, 32'h44, 1, 1, 1, 0, 16'hFFFF), 103);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
